// File: rtl/ras_ckpt.sv
// Return-address stack with per-entry recursion counters and single-cycle checkpoint restore.
// Circular storage: on overflow the oldest entry is overwritten in place, with no shifting.
module ras_ckpt #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int CNT_WIDTH  = 4,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  restore,
  input  logic [PTR_W-1:0]      restore_ptr,
  input  logic [PTR_W:0]        restore_occ,
  input  logic [ADDR_WIDTH-1:0] restore_addr,
  input  logic [CNT_WIDTH-1:0]  restore_cnt,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  top_valid,
  output logic [PTR_W-1:0]      ckpt_ptr,
  output logic [PTR_W:0]        ckpt_occ,
  output logic [ADDR_WIDTH-1:0] ckpt_addr,
  output logic [CNT_WIDTH-1:0]  ckpt_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PTR_W:0]       OCC_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [CNT_WIDTH-1:0]  r_cnt  [DEPTH];
  logic [PTR_W-1:0]      r_tp;
  logic [PTR_W:0]        r_occ;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [ADDR_WIDTH-1:0] w_top_addr;
  logic [CNT_WIDTH-1:0]  w_top_cnt;
  logic [PTR_W-1:0]      w_tp_inc;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_match;
  logic                  w_inc;
  logic                  w_dec;
  logic                  w_replace;
  logic                  w_alloc;
  logic                  w_drop;
  logic                  w_unf;

  assign w_top_addr = r_addr[r_tp];
  assign w_top_cnt  = r_cnt[r_tp];
  assign w_tp_inc   = r_tp + PTR_W'(1);
  assign w_empty    = (r_occ == '0);
  assign w_full     = (r_occ == OCC_FULL);
  assign w_match    = (push_addr == w_top_addr);

  // Decode push/pop into primitive stack actions; restore is handled in the register block.
  always_comb begin
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_replace = 1'b0;
    w_alloc   = 1'b0;
    w_drop    = 1'b0;
    w_unf     = 1'b0;
    if (push && (!pop || w_empty)) begin
      if (!w_empty && w_match && (w_top_cnt < CNT_MAX)) w_inc   = 1'b1;
      else                                               w_alloc = 1'b1;
    end else if (pop && !push) begin
      if (w_empty)                    w_unf  = 1'b1;
      else if (w_top_cnt > CNT_ONE)   w_dec  = 1'b1;
      else                            w_drop = 1'b1;
    end else if (push && pop) begin
      if (!w_match) begin
        if (w_top_cnt > CNT_ONE) begin
          w_dec   = 1'b1;
          w_alloc = 1'b1;
        end else begin
          w_replace = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_tp        <= PTR_W'(DEPTH - 1);
      r_occ       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (restore) begin
      r_tp                 <= restore_ptr;
      r_occ                <= restore_occ;
      r_addr[restore_ptr]  <= restore_addr;
      r_cnt[restore_ptr]   <= restore_cnt;
      r_overflow           <= 1'b0;
      r_underflow          <= 1'b0;
    end else begin
      if (w_inc)     r_cnt[r_tp]  <= w_top_cnt + CNT_ONE;
      if (w_dec)     r_cnt[r_tp]  <= w_top_cnt - CNT_ONE;
      if (w_replace) r_addr[r_tp] <= push_addr;
      // Allocation writes tp+1, never tp, so it cannot collide with a same-cycle decrement.
      if (w_alloc) begin
        r_addr[w_tp_inc] <= push_addr;
        r_cnt[w_tp_inc]  <= CNT_ONE;
        r_tp             <= w_tp_inc;
        if (!w_full) r_occ <= r_occ + (PTR_W+1)'(1);
      end
      if (w_drop) begin
        r_tp  <= r_tp - PTR_W'(1);
        r_occ <= r_occ - (PTR_W+1)'(1);
      end
      r_overflow  <= w_alloc && w_full;
      r_underflow <= w_unf;
    end
  end

  assign top_addr  = w_empty ? '0 : w_top_addr;
  assign top_valid = !w_empty;
  assign ckpt_ptr  = r_tp;
  assign ckpt_occ  = r_occ;
  assign ckpt_addr = w_top_addr;
  assign ckpt_cnt  = w_top_cnt;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt (DEPTH=4, CNT_WIDTH=2): rule-level stack model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_ras_ckpt;

  localparam int AW = 16;
  localparam int D  = 4;
  localparam int CW = 2;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop, restore;
  logic [AW-1:0] push_addr, restore_addr;
  logic [PW-1:0] restore_ptr;
  logic [PW:0]   restore_occ;
  logic [CW-1:0] restore_cnt;
  logic [AW-1:0] top_addr, ckpt_addr;
  logic          top_valid, overflow, underflow;
  logic [PW-1:0] ckpt_ptr;
  logic [PW:0]   ckpt_occ;
  logic [CW-1:0] ckpt_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  ras_ckpt #(.ADDR_WIDTH(AW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .restore(restore), .restore_ptr(restore_ptr), .restore_occ(restore_occ),
    .restore_addr(restore_addr), .restore_cnt(restore_cnt),
    .top_addr(top_addr), .top_valid(top_valid), .ckpt_ptr(ckpt_ptr), .ckpt_occ(ckpt_occ),
    .ckpt_addr(ckpt_addr), .ckpt_cnt(ckpt_cnt), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: stack of (address, repeat count) entries in a ring of D slots.
  int            m_tp, m_occ, m_cnt [D];
  logic [AW-1:0] m_addr [D];
  bit            m_ovf, m_unf, m_live = 0;

  function automatic void m_allocate(input logic [AW-1:0] a);
    m_tp         = (m_tp + 1) % D;
    m_addr[m_tp] = a;
    m_cnt[m_tp]  = 1;
    if (m_occ == D) m_ovf = 1;
    else            m_occ = m_occ + 1;
  endfunction

  always @(posedge clk) begin
    m_ovf = 0;
    m_unf = 0;
    if (rst) begin
      m_tp  = D - 1;
      m_occ = 0;
      for (int i = 0; i < D; i++) begin m_addr[i] = '0; m_cnt[i] = 0; end
      m_live = 1;
    end else if (restore) begin
      m_tp               = int'(restore_ptr);
      m_occ              = int'(restore_occ);
      m_addr[m_tp]       = restore_addr;
      m_cnt[m_tp]        = int'(restore_cnt);
    end else if (push && (!pop || m_occ == 0)) begin
      if (m_occ != 0 && push_addr == m_addr[m_tp] && m_cnt[m_tp] < (1 << CW) - 1)
        m_cnt[m_tp] = m_cnt[m_tp] + 1;
      else
        m_allocate(push_addr);
    end else if (pop && !push) begin
      if (m_occ == 0)           m_unf = 1;
      else if (m_cnt[m_tp] > 1) m_cnt[m_tp] = m_cnt[m_tp] - 1;
      else begin
        m_tp  = (m_tp + D - 1) % D;
        m_occ = m_occ - 1;
      end
    end else if (push && pop && push_addr != m_addr[m_tp]) begin
      if (m_cnt[m_tp] <= 1) m_addr[m_tp] = push_addr;
      else begin
        m_cnt[m_tp] = m_cnt[m_tp] - 1;
        m_allocate(push_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("m_top_valid", 32'(top_valid), 32'(m_occ != 0));
      check("m_top_addr",  32'(top_addr),  (m_occ != 0) ? 32'(m_addr[m_tp]) : 32'h0);
      check("m_ckpt_ptr",  32'(ckpt_ptr),  32'(m_tp));
      check("m_ckpt_occ",  32'(ckpt_occ),  32'(m_occ));
      check("m_ckpt_addr", 32'(ckpt_addr), 32'(m_addr[m_tp]));
      check("m_ckpt_cnt",  32'(ckpt_cnt),  32'(m_cnt[m_tp]));
      check("m_overflow",  32'(overflow),  32'(m_ovf));
      check("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic step(input logic ps, input logic pp, input logic [AW-1:0] a);
    push = ps; pop = pp; push_addr = a;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_restore(input logic [PW-1:0] p, input logic [PW:0] o,
                            input logic [AW-1:0] a, input logic [CW-1:0] c, input logic ps);
    restore = 1'b1; restore_ptr = p; restore_occ = o; restore_addr = a; restore_cnt = c;
    push = ps; push_addr = 16'h0009;
    @(posedge clk);
    @(negedge clk);
    restore = 1'b0; push = 1'b0;
  endtask

  logic [PW-1:0] ck_ptr;
  logic [PW:0]   ck_occ;
  logic [AW-1:0] ck_addr;
  logic [CW-1:0] ck_cnt;

  initial begin
    rst = 1'b1; push = 0; pop = 0; restore = 0; push_addr = '0;
    restore_ptr = '0; restore_occ = '0; restore_addr = '0; restore_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(top_valid), 32'h0);
    check("rst_top",   32'(top_addr),  32'h0);
    check("rst_ptr",   32'(ckpt_ptr),  32'h3);

    // Basic push/pop and underflow
    step(1, 0, 16'h0100);
    check("p1_top", 32'(top_addr), 32'h100);
    check("p1_occ", 32'(ckpt_occ), 32'h1);
    check("p1_ptr", 32'(ckpt_ptr), 32'h0);
    step(0, 1, 16'h0);
    check("pop1_valid", 32'(top_valid), 32'h0);
    step(0, 1, 16'h0);
    check("unf_pulse", 32'(underflow), 32'h1);
    check("unf_occ",   32'(ckpt_occ),  32'h0);
    step(0, 0, 16'h0);
    check("unf_clear", 32'(underflow), 32'h0);

    // Recursion counter saturation
    step(1, 0, 16'h0200);
    step(1, 0, 16'h0200);
    step(1, 0, 16'h0200);
    check("rec_cnt3", 32'(ckpt_cnt), 32'h3);
    check("rec_occ1", 32'(ckpt_occ), 32'h1);
    step(1, 0, 16'h0200);
    check("rec_occ2", 32'(ckpt_occ), 32'h2);
    check("rec_cnt1", 32'(ckpt_cnt), 32'h1);
    repeat (4) step(0, 1, 16'h0);
    check("rec_empty", 32'(top_valid), 32'h0);

    // Wrap-around overflow
    for (int i = 1; i <= 5; i++) step(1, 0, 16'(i * 16));
    check("ovf_pulse", 32'(overflow), 32'h1);
    check("ovf_occ",   32'(ckpt_occ), 32'h4);
    for (int i = 5; i >= 2; i--) begin
      check("ovf_pop_top", 32'(top_addr), 32'(i * 16));
      step(0, 1, 16'h0);
    end
    check("ovf_empty", 32'(top_valid), 32'h0);

    // Simultaneous push+pop
    step(1, 0, 16'h000A);
    step(1, 0, 16'h000A);
    check("pp_cntA", 32'(ckpt_cnt), 32'h2);
    step(1, 1, 16'h000B);
    check("pp_topB", 32'(top_addr), 32'hB);
    check("pp_occ2", 32'(ckpt_occ), 32'h2);
    step(1, 1, 16'h000C);
    check("pp_topC", 32'(top_addr), 32'hC);
    check("pp_occ2b", 32'(ckpt_occ), 32'h2);
    step(1, 1, 16'h000C);
    check("pp_same", 32'(top_addr), 32'hC);
    step(0, 1, 16'h0);
    check("pp_backA", 32'(top_addr), 32'hA);
    check("pp_cntA1", 32'(ckpt_cnt), 32'h1);
    step(0, 1, 16'h0);

    // Checkpoint capture and restore with a colliding push
    step(1, 0, 16'h0001);
    ck_ptr = ckpt_ptr; ck_occ = ckpt_occ; ck_addr = ckpt_addr; ck_cnt = ckpt_cnt;
    step(1, 0, 16'h0002);
    step(1, 0, 16'h0003);
    check("ck_pre_top", 32'(top_addr), 32'h3);
    do_restore(ck_ptr, ck_occ, ck_addr, ck_cnt, 1'b1);
    check("ck_top", 32'(top_addr), 32'h1);
    check("ck_occ", 32'(ckpt_occ), 32'h1);
    check("ck_ovf", 32'(overflow), 32'h0);
    do_restore(2'd2, 3'd0, 16'h0077, 2'd1, 1'b0);
    check("rz_valid", 32'(top_valid), 32'h0);
    check("rz_top",   32'(top_addr),  32'h0);
    check("rz_caddr", 32'(ckpt_addr), 32'h77);
    check("rz_ptr",   32'(ckpt_ptr),  32'h2);

    // Reset overriding restore and push
    step(1, 0, 16'h0055);
    rst = 1'b1;
    do_restore(2'd1, 3'd3, 16'h0066, 2'd2, 1'b1);
    rst = 1'b0;
    check("rr_valid", 32'(top_valid), 32'h0);
    check("rr_occ",   32'(ckpt_occ),  32'h0);
    check("rr_ptr",   32'(ckpt_ptr),  32'h3);
    check("rr_addr",  32'(ckpt_addr), 32'h0);
    check("rr_cnt",   32'(ckpt_cnt),  32'h0);
    step(1, 0, 16'h0123);
    check("rr_first", 32'(ckpt_ptr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
